tb_status_collector: RTL

Registered verdict stage that consumes the `done`/`error` pairs of several memory sub-benches (bus and instruction memory) and produces one sticky, synthesizable pass/fail/timeout result. Sits directly downstream of the memory test aggregation level and feeds the top-level simulation controller or board status LEDs. Captures per-bench error pulses that a purely combinational AND/OR would lose. Adds a run watchdog and failure-origin reporting.

---
 rtl/tb_status_collector.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/tb_status_collector.sv
// Sticky verdict stage for a group of memory sub-benches: latches done/error
// pulses during a run and reports pass, fail or watchdog timeout.
module tb_status_collector #(
    parameter int NUM_TB         = 4,
    parameter int IDX_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_TB-1:0]    tb_done,
    input  logic [NUM_TB-1:0]    tb_error,
    output logic                 done,
    output logic                 error,
    output logic                 timeout,
    output logic                 busy,
    output logic [NUM_TB-1:0]    fail_mask,
    output logic [IDX_WIDTH-1:0] first_fail_idx,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CYCLE = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 state_reg;
    logic [NUM_TB-1:0]      done_seen_reg;
    logic [NUM_TB-1:0]      fail_mask_reg;
    logic                   fail_valid_reg;
    logic [IDX_WIDTH-1:0]   first_fail_idx_reg;
    logic [CNT_WIDTH-1:0]   cycle_count_reg;
    logic                   done_reg;
    logic                   error_reg;
    logic                   timeout_reg;
    logic                   busy_reg;

    logic [NUM_TB-1:0]      done_seen_next;
    logic [NUM_TB-1:0]      fail_mask_next;
    logic                   all_done;
    logic                   any_err;
    logic                   at_limit;
    logic                   cnt_saturated;
    logic [IDX_WIDTH-1:0]   lowest_err_idx;

    // Current-cycle inputs take part in the exit decision, so a bench that
    // finishes or errors on the deciding edge is not missed.
    assign done_seen_next = done_seen_reg | tb_done;
    assign fail_mask_next = fail_mask_reg | tb_error;
    assign all_done       = &done_seen_next;
    assign any_err        = |fail_mask_next;
    assign at_limit       = (cycle_count_reg == LAST_CYCLE);
    assign cnt_saturated  = &cycle_count_reg;

    // Scan downward so the lowest set index is the one left standing.
    always_comb begin
        lowest_err_idx = '0;
        for (int i = NUM_TB - 1; i >= 0; i--) begin
            if (tb_error[i]) begin
                lowest_err_idx = IDX_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= S_IDLE;
            done_seen_reg      <= '0;
            fail_mask_reg      <= '0;
            fail_valid_reg     <= 1'b0;
            first_fail_idx_reg <= '0;
            cycle_count_reg    <= '0;
            done_reg           <= 1'b0;
            error_reg          <= 1'b0;
            timeout_reg        <= 1'b0;
            busy_reg           <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_PASS, S_FAIL, S_TIMEOUT: begin
                    if (start) begin
                        state_reg          <= S_RUN;
                        done_seen_reg      <= '0;
                        fail_mask_reg      <= '0;
                        fail_valid_reg     <= 1'b0;
                        first_fail_idx_reg <= '0;
                        cycle_count_reg    <= '0;
                        done_reg           <= 1'b0;
                        error_reg          <= 1'b0;
                        timeout_reg        <= 1'b0;
                        busy_reg           <= 1'b1;
                    end
                end

                S_RUN: begin
                    done_seen_reg <= done_seen_next;
                    fail_mask_reg <= fail_mask_next;
                    if (!fail_valid_reg && (|tb_error)) begin
                        fail_valid_reg     <= 1'b1;
                        first_fail_idx_reg <= lowest_err_idx;
                    end

                    // The counter is left untouched on the exit edge so it
                    // reports the cycle on which the run was decided.
                    if (all_done) begin
                        state_reg <= any_err ? S_FAIL : S_PASS;
                        done_reg  <= 1'b1;
                        error_reg <= any_err;
                        busy_reg  <= 1'b0;
                    end else if (at_limit) begin
                        state_reg   <= S_TIMEOUT;
                        done_reg    <= 1'b1;
                        error_reg   <= 1'b1;
                        timeout_reg <= 1'b1;
                        busy_reg    <= 1'b0;
                    end else if (!cnt_saturated) begin
                        cycle_count_reg <= cycle_count_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign done           = done_reg;
    assign error          = error_reg;
    assign timeout        = timeout_reg;
    assign busy           = busy_reg;
    assign fail_mask      = fail_mask_reg;
    assign first_fail_idx = first_fail_idx_reg;
    assign cycle_count    = cycle_count_reg;

endmodule
